// File: rtl/neural_pkg.sv
// neural_pkg: Q8.8 format constants and FSM state type shared by the neural datapath.
package neural_pkg;
  localparam int FRAC_BITS = 8;
  localparam int Q_ONE = 1 << FRAC_BITS;
  localparam int Q_MIN = -32768;
  localparam int Q_MAX = 32767;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} sig_inv_state_t;
endpackage

// File: rtl/sigmoid_inverse_sigmoid.sv
// sigmoid: combinational piecewise-linear Q8.8 sigmoid, monotone non-decreasing, output 0..255.
// Ports: i_x signed Q8.8 pre-activation; o_y signed Q8.8 activation.
// Negative inputs mirror around 0.5 via ~x so that sigmoid(-1) = 127 < sigmoid(0) = 128.
module sigmoid #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_x,
  output logic signed [W-1:0] o_y
);
  logic [W-2:0] w_a;
  logic [W-1:0] w_f;
  assign w_a = i_x[W-1] ? ~i_x[W-2:0] : i_x[W-2:0];
  assign w_f = w_a < (W-1)'(256)  ? W'(w_a >> 2) + W'(128) :
               w_a < (W-1)'(608)  ? W'(w_a >> 3) + W'(160) :
               w_a < (W-1)'(1248) ? W'(w_a >> 5) + W'(216) : W'(255);
  assign o_y = i_x[W-1] ? W'(255) - w_f : w_f;
endmodule

// File: rtl/sigmoid_inverse.sv
// sigmoid_inverse: bisection logit, returns smallest Q8.8 x with sigmoid(x) >= y.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/y_in request side;
// out_valid/out_ready/x_out result side; sat clamp flag only when SIGMOID_INV_SAT_EN is defined.
module sigmoid_inverse
  import neural_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = FRAC_BITS,
  parameter int ITER = W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] x_out
`ifdef SIGMOID_INV_SAT_EN
  , output logic              sat
`endif
);
  localparam int CW = $clog2(ITER + 1);
  localparam logic signed [W-1:0] ONE = W'(1) << FRAC;
  sig_inv_state_t r_state;
  logic signed [W-1:0] r_y, r_lo, r_hi, r_x, w_mid, w_sig;
  logic signed [W:0] w_sum;
  logic [CW-1:0] r_cnt;
  logic r_in_ready, r_out_valid;
`ifdef SIGMOID_INV_SAT_EN
  logic r_sat;
  assign sat = r_sat;
`endif
  assign in_ready = r_in_ready;
  assign out_valid = r_out_valid;
  assign x_out = r_x;
  assign w_sum = {r_lo[W-1], r_lo} + {r_hi[W-1], r_hi};
  assign w_mid = w_sum[W:1];
  // After ITER steps lo == hi, so the final cycle reuses sigmoid(mid) as sigmoid(lo).
  sigmoid #(.W(W)) u_sigmoid (.i_x(w_mid), .o_y(w_sig));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_x <= '0;
      r_y <= '0;
      r_lo <= '0;
      r_hi <= '0;
      r_cnt <= '0;
`ifdef SIGMOID_INV_SAT_EN
      r_sat <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_y <= y_in;
          r_in_ready <= 1'b0;
          if (y_in <= 0 || y_in >= ONE) begin
            r_x <= y_in <= 0 ? W'(Q_MIN) : W'(Q_MAX);
`ifdef SIGMOID_INV_SAT_EN
            r_sat <= 1'b1;
`endif
            r_state <= DONE;
          end else begin
            r_lo <= W'(Q_MIN);
            r_hi <= W'(Q_MAX);
            r_cnt <= '0;
            r_state <= SEARCH;
          end
        end
        SEARCH: if (r_cnt == CW'(ITER)) begin
          r_x <= r_lo;
`ifdef SIGMOID_INV_SAT_EN
          r_sat <= w_sig < r_y;
`endif
          r_out_valid <= 1'b1;
          r_state <= DONE;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          if (r_lo != r_hi) begin
            if (w_sig >= r_y) r_hi <= w_mid;
            else r_lo <= w_mid + W'(1);
          end
        end
        // Clamped results enter DONE with out_valid low, giving them a one-edge latency.
        DONE: if (!r_out_valid) r_out_valid <= 1'b1;
        else if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmoid_inverse.sv
// tb_sigmoid_inverse: randomized and swept check of sigmoid_inverse against a table-scan logit model.
module tb_sigmoid_inverse;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic signed [15:0] y_in = 0;
  logic in_ready, out_valid;
  logic signed [15:0] x_out;
`ifdef SIGMOID_INV_SAT_EN
  logic sat;
`endif
  int total = 0, bad = 0;
  int first_ge[256];
  always #5 clk = ~clk;
  sigmoid_inverse dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out)
`ifdef SIGMOID_INV_SAT_EN
    , .sat(sat)
`endif
  );
  function automatic int ref_sig(int x);
    int a = x < 0 ? -x - 1 : x;
    int f = a < 256 ? 128 + a / 4 : a < 608 ? 160 + a / 8 : a < 1248 ? 216 + a / 32 : 255;
    return x < 0 ? 255 - f : f;
  endfunction
  function automatic int ref_inv(int y);
    return y <= 0 ? -32768 : y >= 256 ? 32767 : first_ge[y];
  endfunction
  task automatic check(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_valid(int exp_lat);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 40);
    check("latency", n, exp_lat);
  endtask
  task automatic request(int y, bit inv);
    int x;
    @(negedge clk);
    in_valid = 1;
    y_in = 16'(y);
    check("in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 0;
    wait_valid((y <= 0 || y >= 256) ? 1 : 17);
    x = int'(x_out);
    check("x_out", x, ref_inv(y));
`ifdef SIGMOID_INV_SAT_EN
    check("sat", int'(sat), int'(y <= 0 || y >= 256));
`endif
    if (inv) begin
      check("inv_hi", int'(ref_sig(x) >= y), 1);
      if (x != -32768) check("inv_lo", int'(ref_sig(x - 1) < y), 1);
    end
    @(posedge clk);
    @(negedge clk);
    check("release_ready", int'(in_ready), 1);
    check("release_valid", int'(out_valid), 0);
  endtask
  initial begin
    int lvl = 0, held;
    for (int x = -32768; x <= 32767; x++)
      while (lvl < 256 && lvl <= ref_sig(x)) begin
        first_ge[lvl] = x;
        lvl++;
      end
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x_out", int'(x_out), 0);
    @(negedge clk) rst_n = 1;
    request(128, 1);
    check("logit_half", int'(x_out), 0);
    request(0, 0);
    request(-5, 0);
    request(256, 0);
    request(300, 0);
    for (int y = 1; y <= 255; y++) request(y, 1);
    for (int i = 0; i < 40; i++) request(int'($urandom_range(599)) - 200, 0);
    out_ready = 0;
    @(negedge clk);
    in_valid = 1;
    y_in = 50;
    @(posedge clk);
    #1 in_valid = 0;
    wait_valid(17);
    held = int'(x_out);
    check("hold_x", held, ref_inv(50));
    in_valid = 1;
    y_in = 7;
    repeat (10) begin
      @(negedge clk);
      check("hold_x_stable", int'(x_out), held);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("hold_release_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    check("hold_no_second", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1;
    y_in = 100;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (8) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_x_out", int'(x_out), 0);
    @(negedge clk) rst_n = 1;
    repeat (20) @(negedge clk);
    check("abort_no_result", int'(out_valid), 0);
    request(200, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
